// File: rtl/mul2_hex_display.sv
// Sequential shift-add unsigned multiplier with a four-digit active-low
// hex seven-segment readout of the low 16 bits of the product.
module mul2_hex_display #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SIZE-1:0]   a_in,
  input  logic [SIZE-1:0]   b_in,
  output logic [2*SIZE-1:0] result,
  output logic              busy,
  output logic              done,
  output logic [7:0]        disp0,
  output logic [7:0]        disp1,
  output logic [7:0]        disp2,
  output logic [7:0]        disp3
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     mcand_q, mcand_d;
  logic [2*SIZE:0]     prod_q, prod_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*SIZE-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic [SIZE:0]       upper;
  logic [2*SIZE:0]     step;
  logic [15:0]         disp_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    // Conditional add into the upper half keeps its carry in the extra top bit.
    upper = {1'b0, prod_q[2*SIZE-1:SIZE]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step  = {upper, prod_q[SIZE-1:0]} >> 1;
    case (state_q)
      IDLE: begin
        if (load) begin
          mcand_d = a_in;
          prod_d  = {1'b0, {SIZE{1'b0}}, b_in};
          cnt_d   = CW'(SIZE);
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = step[2*SIZE-1:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (2 * SIZE >= 16) begin : g_wide
      assign disp_val = result_q[15:0];
    end else begin : g_narrow
      assign disp_val = {{(16 - 2 * SIZE){1'b0}}, result_q};
    end
  endgenerate

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  assign result = result_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign disp0  = seg7(disp_val[3:0]);
  assign disp1  = seg7(disp_val[7:4]);
  assign disp2  = seg7(disp_val[11:8]);
  assign disp3  = seg7(disp_val[15:12]);

endmodule

// File: tb/tb_mul2_hex_display.sv
// Directed self-checking bench for mul2_hex_display (SIZE=8) using
// immediate assertions with hand-computed expected values.
module tb_mul2_hex_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic [7:0]  disp0, disp1, disp2, disp3;

  int total = 0;
  int bad   = 0;

  mul2_hex_display #(.SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .a_in(a_in), .b_in(b_in),
    .result(result), .busy(busy), .done(done),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkDisp(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
    checkOutput({tag, "_d3"}, 32'(disp3), 32'(d3));
    checkOutput({tag, "_d2"}, 32'(disp2), 32'(d2));
    checkOutput({tag, "_d1"}, 32'(disp1), 32'(d1));
    checkOutput({tag, "_d0"}, 32'(disp0), 32'(d0));
  endtask

  // Pulses load for one edge, then checks exact latency: done rises after
  // the eighth edge following the load edge, result holds until then.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] prev, input logic [15:0] exp);
    @(negedge clk);
    a_in = a;
    b_in = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    checkOutput({tag, "_done_clr"}, 32'(done), 32'd0);
    repeat (7) @(negedge clk);
    checkOutput({tag, "_busy_mid"}, 32'(busy), 32'd1);
    checkOutput({tag, "_hold"}, 32'(result), 32'(prev));
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  logic [7:0] seg_tab [16];

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst_n = 1'b0;
    load  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkDisp("rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("m0f0f", 8'h0F, 8'h0F, 16'h0000, 16'h00E1);
    checkDisp("m0f0f", 8'hC0, 8'hC0, 8'h86, 8'hF9);

    applyStimulus("mffff", 8'hFF, 8'hFF, 16'h00E1, 16'hFE01);
    checkDisp("mffff", 8'h8E, 8'h86, 8'hC0, 8'hF9);

    applyStimulus("m00a5", 8'h00, 8'hA5, 16'hFE01, 16'h0000);
    checkDisp("m00a5", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    applyStimulus("m01a5", 8'h01, 8'hA5, 16'h0000, 16'h00A5);
    checkDisp("m01a5", 8'hC0, 8'hC0, 8'h88, 8'h92);

    // Busy protection: a second load during RUN must be ignored.
    @(negedge clk);
    a_in = 8'h03;
    b_in = 8'h05;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in = 8'hFF;
    b_in = 8'hFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput("prot_busy", 32'(busy), 32'd1);
    checkOutput("prot_hold", 32'(result), 32'h00A5);
    repeat (4) @(negedge clk);
    checkOutput("prot_notdone", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("prot_done", 32'(done), 32'd1);
    checkOutput("prot_result", 32'(result), 32'h000F);
    @(negedge clk);
    checkOutput("prot_norestart", 32'(busy), 32'd0);

    // Load held high: restarts on the first edge back in IDLE.
    @(negedge clk);
    a_in = 8'h02;
    b_in = 8'h03;
    load = 1'b1;
    repeat (9) @(negedge clk);
    checkOutput("held_done", 32'(done), 32'd1);
    checkOutput("held_result", 32'(result), 32'h0006);
    @(negedge clk);
    load = 1'b0;
    checkOutput("held_restart", 32'(busy), 32'd1);
    checkOutput("held_doneclr", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("held_idle", 32'(busy), 32'd0);

    for (int n = 0; n < 16; n++) begin
      applyStimulus($sformatf("sweep%0d", n), 8'(n), 8'h01,
                    (n == 0) ? 16'h0006 : 16'(n - 1), 16'(n));
      checkDisp($sformatf("sweep%0d", n), 8'hC0, 8'hC0, 8'hC0, seg_tab[n]);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a_in = 8'h0F;
    b_in = 8'h0F;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_result", 32'(result), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkDisp("arst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_stay_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
